// File: rtl/boot_pkg.sv
// Shared types and constants for the serial boot loader.
package boot_pkg;

  typedef enum logic [2:0] {IDLE, SIZE0, SIZE1, DATA, CHK, RUN} boot_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;
  localparam int         CLK_HZ       = 50_000_000;
  localparam int         BAUD         = 115_200;

  // Truncating divide gives 434 for 50 MHz / 115200
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  localparam int CLKS_PER_BIT_DEF = baud_div(CLK_HZ, BAUD);

endpackage

// File: rtl/ser_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, centre-sampling bit timer, LSB-first shifter.
module ser_rx_byte
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam logic [15:0] FULL_TICK = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_TICK = 16'(CLKS_PER_BIT / 2 - 1);

  rx_state_t   state, next_state;
  logic        rxd_meta, rxd_sync, rxd_prev;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        full_tick, half_tick, fall;

  assign full_tick = (timer == FULL_TICK);
  assign half_tick = (timer == HALF_TICK);
  assign fall      = rxd_prev & ~rxd_sync;
  assign rx_data   = shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= next_state;
  end

  // A start edge that is high again at half a bit is treated as a glitch
  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (fall) next_state = RX_START;
      RX_START: if (half_tick) next_state = rxd_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (full_tick) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    if (state == RX_STOP && full_tick) begin
      rx_valid = rxd_sync;
      rx_ferr  = ~rxd_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == RX_IDLE || next_state != state || full_tick) timer <= '0;
      else                                                       timer <= timer + 16'd1;
      if (state == RX_IDLE) bit_idx <= '0;
      if (state == RX_DATA && full_tick) begin
        shreg   <= {rxd_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ser_boot_loader.sv
// Loads a framed, XOR-checksummed program image from the UART into memory,
// holding the core in reset until the load finishes or the idle timeout expires.
module ser_boot_loader
  import boot_pkg::*;
#(
  parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int         MEM_AW       = 11,
  parameter int         TIMEOUT_CYC  = 50_000_000,
  parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ser_rxd,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dout,
  output logic [3:0]  mem_wr_en,
  output logic        core_rst,
  output logic        busy,
  output logic        boot_err
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** MEM_AW);

  boot_state_t       state, next_state;
  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr;
  logic [31:0]       timeout_cnt;
  logic [7:0]        size_lo, chk;
  logic [15:0]       word_total, words_done, size_rx;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [MEM_AW-1:0] word_addr;
  logic              hdr_seen, wr_fire, err_evt, timed_out;

  ser_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd      (ser_rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign size_rx    = {rx_data, size_lo};
  assign timed_out  = (timeout_cnt == 32'(TIMEOUT_CYC - 1));
  assign mem_addr_o = {{(30 - MEM_AW){1'b0}}, word_addr, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (hdr_seen)       next_state = SIZE0;
        else if (timed_out) next_state = RUN;
      end
      SIZE0: begin
        if (err_evt)       next_state = IDLE;
        else if (rx_valid) next_state = SIZE1;
      end
      SIZE1: begin
        if (err_evt)       next_state = IDLE;
        else if (rx_valid) next_state = (size_rx == 16'd0) ? CHK : DATA;
      end
      DATA: begin
        if (err_evt) next_state = IDLE;
        else if (wr_fire && words_done == word_total - 16'd1) next_state = CHK;
      end
      CHK: begin
        if (err_evt)       next_state = IDLE;
        else if (rx_valid) next_state = RUN;
      end
      RUN:     next_state = RUN;
      default: next_state = IDLE;
    endcase
  end

  // Error covers framing, oversize image and checksum mismatch
  always_comb begin
    busy     = 1'b0;
    hdr_seen = 1'b0;
    wr_fire  = 1'b0;
    err_evt  = 1'b0;
    case (state)
      IDLE:  hdr_seen = rx_valid && (rx_data == HDR_BYTE);
      SIZE0: begin
        busy    = 1'b1;
        err_evt = rx_ferr;
      end
      SIZE1: begin
        busy    = 1'b1;
        err_evt = rx_ferr || (rx_valid && ({1'b0, size_rx} > MAX_WORDS));
      end
      DATA: begin
        busy    = 1'b1;
        err_evt = rx_ferr;
        wr_fire = rx_valid && (byte_idx == 2'd3);
      end
      CHK: begin
        busy    = 1'b1;
        err_evt = rx_ferr || (rx_valid && (rx_data != chk));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_cnt <= '0;
      size_lo     <= '0;
      word_total  <= '0;
      words_done  <= '0;
      chk         <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      word_addr   <= '0;
      mem_dout    <= '0;
      mem_wr_en   <= '0;
      core_rst    <= 1'b1;
      boot_err    <= 1'b0;
    end else begin
      mem_wr_en <= '0;
      core_rst  <= (state != RUN);
      if (state == IDLE && next_state == IDLE) timeout_cnt <= timeout_cnt + 32'd1;
      else                                     timeout_cnt <= '0;
      if (hdr_seen) begin
        boot_err   <= 1'b0;
        chk        <= '0;
        byte_idx   <= '0;
        words_done <= '0;
        word_addr  <= '0;
      end
      if (state == SIZE0 && rx_valid) size_lo    <= rx_data;
      if (state == SIZE1 && rx_valid) word_total <= size_rx;
      if (state == DATA && rx_valid) begin
        chk      <= chk ^ rx_data;
        byte_idx <= byte_idx + 2'd1;
        word_buf <= {rx_data, word_buf[23:8]};
      end
      // Address moves only after the write cycle so it is stable during the pulse
      if (wr_fire) begin
        mem_dout   <= {rx_data, word_buf};
        mem_wr_en  <= 4'b1111;
        words_done <= words_done + 16'd1;
      end else if (mem_wr_en != 4'b0000) begin
        word_addr <= word_addr + 1'b1;
      end
      if (err_evt) begin
        boot_err  <= 1'b1;
        word_addr <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ser_boot_loader.sv
// Directed bench for ser_boot_loader with a short bit period and 1000-cycle timeout.
module tb_ser_boot_loader;

  localparam int CPB = 16;
  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ser_rxd = 1'b1;
  logic [31:0] mem_addr_o, mem_dout;
  logic [3:0]  mem_wr_en;
  logic        core_rst, busy, boot_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc;
  int wr_count;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [3:0]  wr_en_v [8];

  always #5 clk = ~clk;

  ser_boot_loader #(
    .CLKS_PER_BIT (CPB),
    .MEM_AW       (11),
    .TIMEOUT_CYC  (TMO),
    .HDR_BYTE     (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_rxd    (ser_rxd),
    .mem_addr_o (mem_addr_o),
    .mem_dout   (mem_dout),
    .mem_wr_en  (mem_wr_en),
    .core_rst   (core_rst),
    .busy       (busy),
    .boot_err   (boot_err)
  );

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Write monitor: one entry per cycle the write enable is seen high
  always @(negedge clk) begin
    if (!rst) wr_count = 0;
    else if (mem_wr_en != 4'b0000) begin
      if (wr_count < 8) begin
        wr_addr[wr_count] = mem_addr_o;
        wr_data[wr_count] = mem_dout;
        wr_en_v[wr_count] = mem_wr_en;
      end
      wr_count++;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic apply_reset();
    rst = 1'b0;
    ser_rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop_bit);
    ser_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    ser_rxd = 1'b1;
  endtask

  task automatic send_glitch();
    ser_rxd = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    ser_rxd = 1'b1;
  endtask

  task automatic send_body(input logic [7:0] chk_b);
    logic [7:0] body [10];
    body = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 10; i++) uart_send(body[i], 1'b1);
    uart_send(chk_b, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL reset_addr: got %h want 0", mem_addr_o); else pass_cnt++;
    total_cnt++; if (mem_dout !== 32'h0) $display("[TB] FAIL reset_dout: got %h want 0", mem_dout); else pass_cnt++;
    total_cnt++; if (mem_wr_en !== 4'h0) $display("[TB] FAIL reset_wr_en: got %h want 0", mem_wr_en); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b1) $display("[TB] FAIL reset_core_rst: got %b want 1", core_rst); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (boot_err !== 1'b0) $display("[TB] FAIL reset_boot_err: got %b want 0", boot_err); else pass_cnt++;
  endtask

  task automatic test_timeout_noise();
    int rel;
    apply_reset();
    repeat (50) @(negedge clk);
    send_glitch();
    repeat (50) @(negedge clk);
    uart_send(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL noise_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b1) $display("[TB] FAIL noise_core_rst: got %b want 1", core_rst); else pass_cnt++;
    for (int g = 0; g < 3000 && core_rst; g++) @(negedge clk);
    rel = cyc;
    total_cnt++; if (rel < 999 || rel > 1001) $display("[TB] FAIL timeout_cycle: got %0d want 999..1001", rel); else pass_cnt++;
    total_cnt++; if (wr_count !== 0) $display("[TB] FAIL timeout_writes: got %0d want 0", wr_count); else pass_cnt++;
    total_cnt++; if (boot_err !== 1'b0) $display("[TB] FAIL timeout_boot_err: got %b want 0", boot_err); else pass_cnt++;
  endtask

  task automatic test_good_load();
    apply_reset();
    repeat (10) @(negedge clk);
    send_glitch();
    repeat (20) @(negedge clk);
    uart_send(8'hA5, 1'b1);
    send_body(8'h2A);
    repeat (5) @(negedge clk);
    total_cnt++; if (wr_count !== 2) $display("[TB] FAIL good_wr_count: got %0d want 2", wr_count); else pass_cnt++;
    total_cnt++; if (wr_addr[0] !== 32'h0) $display("[TB] FAIL good_addr0: got %h want 0", wr_addr[0]); else pass_cnt++;
    total_cnt++; if (wr_data[0] !== 32'h12345678) $display("[TB] FAIL good_data0: got %h want 12345678", wr_data[0]); else pass_cnt++;
    total_cnt++; if (wr_en_v[0] !== 4'hF) $display("[TB] FAIL good_en0: got %h want f", wr_en_v[0]); else pass_cnt++;
    total_cnt++; if (wr_addr[1] !== 32'h4) $display("[TB] FAIL good_addr1: got %h want 4", wr_addr[1]); else pass_cnt++;
    total_cnt++; if (wr_data[1] !== 32'hDEADBEEF) $display("[TB] FAIL good_data1: got %h want deadbeef", wr_data[1]); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b0) $display("[TB] FAIL good_core_rst: got %b want 0", core_rst); else pass_cnt++;
    total_cnt++; if (boot_err !== 1'b0) $display("[TB] FAIL good_boot_err: got %b want 0", boot_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL good_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h8) $display("[TB] FAIL good_final_addr: got %h want 8", mem_addr_o); else pass_cnt++;
  endtask

  task automatic test_bad_checksum();
    apply_reset();
    uart_send(8'hA5, 1'b1);
    send_body(8'h2B);
    repeat (5) @(negedge clk);
    total_cnt++; if (wr_count !== 2) $display("[TB] FAIL badchk_wr_count: got %0d want 2", wr_count); else pass_cnt++;
    total_cnt++; if (wr_data[1] !== 32'hDEADBEEF) $display("[TB] FAIL badchk_data1: got %h want deadbeef", wr_data[1]); else pass_cnt++;
    total_cnt++; if (boot_err !== 1'b1) $display("[TB] FAIL badchk_boot_err: got %b want 1", boot_err); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b1) $display("[TB] FAIL badchk_core_rst: got %b want 1", core_rst); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL badchk_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL badchk_addr: got %h want 0", mem_addr_o); else pass_cnt++;
    uart_send(8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    total_cnt++; if (boot_err !== 1'b0) $display("[TB] FAIL badchk_hdr_clear: got %b want 0", boot_err); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL badchk_hdr_busy: got %b want 1", busy); else pass_cnt++;
    send_body(8'h2A);
    repeat (5) @(negedge clk);
    total_cnt++; if (core_rst !== 1'b0) $display("[TB] FAIL reload_core_rst: got %b want 0", core_rst); else pass_cnt++;
    total_cnt++; if (wr_count !== 4) $display("[TB] FAIL reload_wr_count: got %0d want 4", wr_count); else pass_cnt++;
    total_cnt++; if (wr_addr[2] !== 32'h0) $display("[TB] FAIL reload_addr0: got %h want 0", wr_addr[2]); else pass_cnt++;
    total_cnt++; if (wr_data[3] !== 32'hDEADBEEF) $display("[TB] FAIL reload_data1: got %h want deadbeef", wr_data[3]); else pass_cnt++;
  endtask

  task automatic test_framing_error();
    apply_reset();
    uart_send(8'hA5, 1'b1);
    uart_send(8'h02, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h78, 1'b1);
    uart_send(8'h56, 1'b1);
    uart_send(8'h34, 1'b0);
    repeat (5) @(negedge clk);
    total_cnt++; if (boot_err !== 1'b1) $display("[TB] FAIL ferr_boot_err: got %b want 1", boot_err); else pass_cnt++;
    total_cnt++; if (wr_count !== 0) $display("[TB] FAIL ferr_writes: got %0d want 0", wr_count); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL ferr_addr: got %h want 0", mem_addr_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ferr_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b1) $display("[TB] FAIL ferr_core_rst: got %b want 1", core_rst); else pass_cnt++;
  endtask

  task automatic test_reset_mid_transfer();
    logic [7:0] head [8];
    head = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
    apply_reset();
    for (int i = 0; i < 8; i++) uart_send(head[i], 1'b1);
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL mid_busy: got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (mem_addr_o !== 32'h4) $display("[TB] FAIL mid_addr: got %h want 4", mem_addr_o); else pass_cnt++;
    total_cnt++; if (mem_dout !== 32'h12345678) $display("[TB] FAIL mid_dout: got %h want 12345678", mem_dout); else pass_cnt++;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    total_cnt++; if (mem_addr_o !== 32'h0) $display("[TB] FAIL async_addr: got %h want 0", mem_addr_o); else pass_cnt++;
    total_cnt++; if (mem_dout !== 32'h0) $display("[TB] FAIL async_dout: got %h want 0", mem_dout); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b1) $display("[TB] FAIL async_core_rst: got %b want 1", core_rst); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL async_busy: got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (boot_err !== 1'b0) $display("[TB] FAIL async_boot_err: got %b want 0", boot_err); else pass_cnt++;
    apply_reset();
    uart_send(8'hA5, 1'b1);
    send_body(8'h2A);
    repeat (5) @(negedge clk);
    total_cnt++; if (wr_count !== 2) $display("[TB] FAIL fresh_wr_count: got %0d want 2", wr_count); else pass_cnt++;
    total_cnt++; if (wr_addr[0] !== 32'h0) $display("[TB] FAIL fresh_addr0: got %h want 0", wr_addr[0]); else pass_cnt++;
    total_cnt++; if (wr_data[0] !== 32'h12345678) $display("[TB] FAIL fresh_data0: got %h want 12345678", wr_data[0]); else pass_cnt++;
    total_cnt++; if (wr_addr[1] !== 32'h4) $display("[TB] FAIL fresh_addr1: got %h want 4", wr_addr[1]); else pass_cnt++;
    total_cnt++; if (core_rst !== 1'b0) $display("[TB] FAIL fresh_core_rst: got %b want 0", core_rst); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_timeout_noise();
    test_good_load();
    test_bad_checksum();
    test_framing_error();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ser_boot_loader.md
Name: ser_boot_loader

Overview:
Serial program loader between the board UART pin and the 8 KB unified memory write port.
- After reset it holds the core in reset and listens on ser_rxd for a framed program image.
- It writes each 32-bit word into memory sequentially from address 0, checks an XOR checksum, then releases the core.
- If no image header arrives within a timeout, the core is released to run the existing memory contents.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200 baud).
MEM_AW, 11, word-address width; 2048 words = 8 KB.
TIMEOUT_CYC, 50_000_000, cycles in IDLE before auto-release (1 s).
HDR_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  system clock (PLL output).
rst  in  1  asynchronous, active-low reset; low = reset.
ser_rxd  in  1  UART receive line, idle high, 8N1, asynchronous to clk.
mem_addr_o  out  32  byte address to memory; bits [1:0] always 0.
mem_dout  out  32  write data to memory.
mem_wr_en  out  4  byte-lane write enables; 4'b1111 for one cycle per word, else 0.
core_rst  out  1  active-high reset to mips_sys; 1 until load completes or times out.
busy  out  1  1 while an image transfer is in progress (SIZE through CHK states).
boot_err  out  1  sticky; set on checksum or framing error, cleared by the next valid HDR_BYTE.

Behaviour:
Reset values (rst low): mem_addr_o=0, mem_dout=0, mem_wr_en=0, core_rst=1, busy=0, boot_err=0, state IDLE, all counters 0.

Receiver:
- ser_rxd passes through a 2-FF synchroniser.
- A falling edge starts a byte; the line is re-sampled at CLKS_PER_BIT/2. If high there, it was a glitch: return to idle.
- Data bits are sampled LSB-first at bit centres; the stop bit is sampled at its centre.
- Stop bit = 1: emit rx_valid for one cycle with rx_data.
- Stop bit = 0: emit rx_ferr for one cycle and no rx_valid.

States:
- IDLE: counts cycles.
  - rx_valid with HDR_BYTE -> SIZE0; clears the timeout counter and boot_err.
  - Any other byte is ignored.
  - Timeout counter reaching TIMEOUT_CYC-1 -> RUN.
- SIZE0, SIZE1: word count N, little-endian 16 bits.
  - N=0 -> CHK directly.
  - N>2**MEM_AW -> set boot_err, back to IDLE.
- DATA: assemble 4 bytes little-endian (first byte -> [7:0]).
  - The 4th byte loads mem_dout and pulses mem_wr_en=4'b1111 for exactly one cycle; mem_addr_o is stable in that cycle.
  - mem_addr_o advances by 4 on the cycle after the write.
  - Each data byte XORs into the running chk register (reset to 0 at HDR_BYTE).
  - After the N-th word -> CHK.
- CHK: the next byte is compared to chk.
  - Equal -> RUN.
  - Not equal -> boot_err=1, mem_addr_o=0, -> IDLE with the timeout counter restarted.
- RUN: core_rst=0 permanently. The receiver is ignored; only rst exits RUN.

Error handling, timeout and reset rules:
- rx_ferr in any of SIZE0..CHK -> boot_err=1, back to IDLE, mem_addr_o=0. Words already written stay in memory.
- The timeout applies only in IDLE. There is no inter-byte timeout once busy.
- Reset mid-transfer immediately returns to the reset values. Partial memory contents are undefined.
- core_rst is registered and deasserts the cycle after entering RUN. Core-side reset synchronisation stays in the top level.

Decomposition:
Shared package (boot_pkg):
- State enum: IDLE, SIZE0, SIZE1, DATA, CHK, RUN.
- HDR_BYTE default.
- Baud constant derivation for 50 MHz.

Sub-module ser_rx_byte: synchroniser, bit timer, shift register.
- Ports: clk, rst, rxd, rx_data[7:0], rx_valid, rx_ferr.
- Parameter: CLKS_PER_BIT.

Top FSM, address counter and checksum live in ser_boot_loader.

Test Plan:
1. Idle timeout: no serial activity, TIMEOUT_CYC=1000 -> core_rst falls at cycle 1000±1 after rst release; mem_wr_en never asserted.
2. Good load: send A5 02 00 | 78 56 34 12 | EF BE AD DE | chk=0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE.
   - Required: writes 0x12345678 at addr 0 and 0xDEADBEEF at addr 4, one pulse each.
   - Then core_rst=0 and boot_err=0.
3. Bad checksum: same image with chk XOR 0x01.
   - Required: both writes occur, boot_err=1, core_rst stays 1, state IDLE.
   - A following valid image clears boot_err and releases core_rst.
4. Framing error: drive the stop bit low on the 3rd data byte -> boot_err=1, no write pulse, mem_addr_o=0.
5. Glitch and noise:
   - Start glitch: ser_rxd low for CLKS_PER_BIT/4 only -> no byte received.
   - Non-header byte 0x3C in IDLE -> ignored, no timeout reset.
6. Reset mid-transfer: assert rst low after 5 data bytes -> all outputs at reset values asynchronously; a fresh image loads correctly from address 0.
